// File: rtl/if_fetch_unit.sv
`timescale 1ns/1ps
// if_fetch_unit: instruction fetch stage. Owns the PC, issues one read per
// cycle to instruction memory while there is room, buffers returned words in a
// DEPTH-entry FIFO of {pc, instruction}, and hands the head to the ID stage
// over a valid/ready handshake. A redirect flushes buffered and in-flight work.
//
// Ports:
//   i_clk             clock, all state on rising edge
//   i_rst             synchronous active-high reset
//   o_imem_req        read request this cycle
//   o_imem_addr       byte address of the request (current PC)
//   i_imem_rdata      read data, valid the cycle after o_imem_req
//   i_redirect        load i_redirect_target into the PC and flush
//   i_redirect_target new PC (bits [1:0] ignored)
//   i_id_ready        ID accepts the head this cycle
//   o_id_valid        FIFO head is valid
//   o_instructions    FIFO head instruction word
//   o_pc_out          PC of the FIFO head instruction
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_target,
  input  logic        i_id_ready,
  output logic        o_id_valid,
  output logic [31:0] o_instructions,
  output logic [31:0] o_pc_out
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = CW + 1;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   r_pc;
  logic [31:0]   r_req_addr;
  logic [CW-1:0] r_count;
  logic          r_inflight;
  logic          r_discard;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [31:0]   r_fifo_pc    [DEPTH];
  logic [31:0]   r_fifo_instr [DEPTH];
  logic [31:0]   r_last_pc;
  logic [31:0]   r_last_instr;

  logic          w_pop;
  logic          w_push;
  logic          w_issue;
  logic [OW-1:0] w_occ_after_pop;
  logic          w_unused_tgt_lsb;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_unused_tgt_lsb = ^i_redirect_target[1:0];

  // Handshake and issue decisions; occupancy counts the in-flight word so the
  // FIFO can never overflow when it returns.
  assign o_id_valid      = (r_count != '0);
  assign w_pop           = o_id_valid & i_id_ready;
  assign w_push          = r_inflight & ~r_discard;
  assign w_occ_after_pop = OW'(r_count) + OW'(r_inflight) - OW'(w_pop);
  assign w_issue         = ~i_rst & ~i_redirect & (w_occ_after_pop < OW'(DEPTH));

  assign o_imem_req  = w_issue;
  assign o_imem_addr = r_pc;

  // When empty the outputs hold the last delivered word.
  assign o_instructions = o_id_valid ? r_fifo_instr[r_rd_ptr] : r_last_instr;
  assign o_pc_out       = o_id_valid ? r_fifo_pc[r_rd_ptr]    : r_last_pc;

  // PC, occupancy and pointer control.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc         <= {RESET_PC[31:2], 2'b00};
      r_req_addr   <= '0;
      r_count      <= '0;
      r_inflight   <= 1'b0;
      r_discard    <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_last_pc    <= '0;
      r_last_instr <= '0;
    end else begin
      if (w_pop) begin
        r_last_pc    <= r_fifo_pc[r_rd_ptr];
        r_last_instr <= r_fifo_instr[r_rd_ptr];
      end
      if (i_redirect) begin
        // A same-cycle pop counts as taken; everything else is flushed.
        r_pc       <= {i_redirect_target[31:2], 2'b00};
        r_count    <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_discard  <= r_inflight;
        r_inflight <= 1'b0;
      end else begin
        r_discard  <= 1'b0;
        r_inflight <= w_issue;
        if (w_issue) begin
          r_pc       <= r_pc + 32'd4;
          r_req_addr <= r_pc;
        end
        if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
        if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  // FIFO storage; contents are only observed through valid entries.
  always_ff @(posedge i_clk) begin
    if (!i_rst && !i_redirect && w_push) begin
      r_fifo_pc[r_wr_ptr]    <= r_req_addr;
      r_fifo_instr[r_wr_ptr] <= i_imem_rdata;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
`timescale 1ns/1ps
// Bench for if_fetch_unit: per-cycle scoreboard of requested PCs; each popped
// head must match the oldest outstanding PC and the memory word for it.
module tb_if_fetch_unit;

  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] instructions;
  logic [31:0] pc_out;

  int unsigned chk_cnt = 0;
  int unsigned pass_cnt = 0;
  logic [31:0] exp_addr;
  logic [31:0] exp_q[$];

  if_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_rdata(imem_rdata),
    .i_redirect(redirect), .i_redirect_target(redirect_target),
    .i_id_ready(id_ready), .o_id_valid(id_valid),
    .o_instructions(instructions), .o_pc_out(pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a == 32'h0) ? 32'hC9A1_FFFF : a + 32'h100;
  endfunction

  // Instruction memory: one-cycle read latency, garbage when not requested.
  always @(posedge clk) imem_rdata <= imem_req ? memf(imem_addr) : 32'hDEAD_BEEF;

  task automatic test_reset();
    rst = 1'b1; redirect = 1'b0; redirect_target = '0; id_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_cnt++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %b need 0", imem_req); else pass_cnt++;
    chk_cnt++; if (id_valid !== 1'b0) $display("FAIL reset_valid: got %b need 0", id_valid); else pass_cnt++;
    chk_cnt++; if (instructions !== 32'h0) $display("FAIL reset_instr: got %h need 0", instructions); else pass_cnt++;
    chk_cnt++; if (pc_out !== 32'h0) $display("FAIL reset_pc: got %h need 0", pc_out); else pass_cnt++;
    exp_q.delete();
    exp_addr = RESET_PC;
  endtask

  task automatic test_stream();
    int first_req = -1;
    int first_valid = -1;
    int occ;
    logic exp_req;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rst = 1'b0; redirect = 1'b0; redirect_target = '0; id_ready = 1'b1;
      #1;
      if (first_req < 0 && imem_req === 1'b1) first_req = i;
      if (first_valid < 0 && id_valid === 1'b1) first_valid = i;
      occ = exp_q.size();
      if (id_valid === 1'b1 && id_ready) occ--;
      exp_req = (occ < int'(DEPTH));
      chk_cnt++;
      if (imem_req !== exp_req) $display("FAIL stream_req c%0d: got %b need %b", i, imem_req, exp_req); else pass_cnt++;
      if (exp_req && imem_req === 1'b1) begin
        chk_cnt++;
        if (imem_addr !== exp_addr) $display("FAIL stream_addr c%0d: got %h need %h", i, imem_addr, exp_addr); else pass_cnt++;
      end
      if (id_valid === 1'b1) begin
        chk_cnt++;
        if (exp_q.size() == 0) $display("FAIL stream_head c%0d: unexpected pc %h", i, pc_out);
        else if (pc_out !== exp_q[0] || instructions !== memf(exp_q[0]))
          $display("FAIL stream_head c%0d: got %h/%h need %h/%h", i, pc_out, instructions, exp_q[0], memf(exp_q[0]));
        else pass_cnt++;
        if (id_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (exp_req) begin exp_q.push_back(exp_addr); exp_addr += 32'd4; end
    end
    chk_cnt++;
    if (first_req != 0 || first_valid != 2)
      $display("FAIL stream_latency: first req c%0d valid c%0d need c0 c2", first_req, first_valid);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int occ;
    logic exp_req;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      rst = 1'b0; redirect = 1'b0; redirect_target = '0; id_ready = (i >= 5);
      #1;
      occ = exp_q.size();
      if (id_valid === 1'b1 && id_ready) occ--;
      exp_req = (occ < int'(DEPTH));
      chk_cnt++;
      if (imem_req !== exp_req) $display("FAIL bp_req c%0d: got %b need %b", i, imem_req, exp_req); else pass_cnt++;
      if (exp_req && imem_req === 1'b1) begin
        chk_cnt++;
        if (imem_addr !== exp_addr) $display("FAIL bp_addr c%0d: got %h need %h", i, imem_addr, exp_addr); else pass_cnt++;
      end
      if (id_valid === 1'b1) begin
        chk_cnt++;
        if (exp_q.size() == 0) $display("FAIL bp_head c%0d: unexpected pc %h", i, pc_out);
        else if (pc_out !== exp_q[0] || instructions !== memf(exp_q[0]))
          $display("FAIL bp_head c%0d: got %h/%h need %h/%h", i, pc_out, instructions, exp_q[0], memf(exp_q[0]));
        else pass_cnt++;
        if (id_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (exp_req) begin exp_q.push_back(exp_addr); exp_addr += 32'd4; end
    end
  endtask

  task automatic test_redirect_inflight();
    int occ;
    logic exp_req;
    logic rd;
    logic [31:0] tg;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rd = (i == 0) || (i == 6);
      tg = (i == 0) ? 32'h0 : 32'h40;
      rst = 1'b0; redirect = rd; redirect_target = tg; id_ready = 1'b1;
      #1;
      occ = exp_q.size();
      if (id_valid === 1'b1 && id_ready) occ--;
      exp_req = !rd && (occ < int'(DEPTH));
      chk_cnt++;
      if (imem_req !== exp_req) $display("FAIL rdi_req c%0d: got %b need %b", i, imem_req, exp_req); else pass_cnt++;
      if (exp_req && imem_req === 1'b1) begin
        chk_cnt++;
        if (imem_addr !== exp_addr) $display("FAIL rdi_addr c%0d: got %h need %h", i, imem_addr, exp_addr); else pass_cnt++;
      end
      if (id_valid === 1'b1) begin
        chk_cnt++;
        if (exp_q.size() == 0) $display("FAIL rdi_head c%0d: unexpected pc %h", i, pc_out);
        else if (pc_out !== exp_q[0] || instructions !== memf(exp_q[0]))
          $display("FAIL rdi_head c%0d: got %h/%h need %h/%h", i, pc_out, instructions, exp_q[0], memf(exp_q[0]));
        else pass_cnt++;
        if (id_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (i == 7) begin
        chk_cnt++;
        if (id_valid !== 1'b0) $display("FAIL rdi_flush: id_valid got %b need 0", id_valid); else pass_cnt++;
      end
      if (i == 9) begin
        chk_cnt++;
        if (id_valid !== 1'b1 || pc_out !== 32'h40)
          $display("FAIL rdi_first: valid %b pc %h need 1 00000040", id_valid, pc_out);
        else pass_cnt++;
      end
      if (rd) begin exp_q.delete(); exp_addr = {tg[31:2], 2'b00}; end
      else if (exp_req) begin exp_q.push_back(exp_addr); exp_addr += 32'd4; end
    end
  endtask

  task automatic test_redirect_full();
    int occ;
    logic exp_req;
    logic rd;
    logic [31:0] tg;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      rd = (i == 4);
      tg = 32'h0000_1003;
      rst = 1'b0; redirect = rd; redirect_target = tg; id_ready = (i >= 5);
      #1;
      occ = exp_q.size();
      if (id_valid === 1'b1 && id_ready) occ--;
      exp_req = !rd && (occ < int'(DEPTH));
      chk_cnt++;
      if (imem_req !== exp_req) $display("FAIL rdf_req c%0d: got %b need %b", i, imem_req, exp_req); else pass_cnt++;
      if (exp_req && imem_req === 1'b1) begin
        chk_cnt++;
        if (imem_addr !== exp_addr) $display("FAIL rdf_addr c%0d: got %h need %h", i, imem_addr, exp_addr); else pass_cnt++;
      end
      if (id_valid === 1'b1) begin
        chk_cnt++;
        if (exp_q.size() == 0) $display("FAIL rdf_head c%0d: unexpected pc %h", i, pc_out);
        else if (pc_out !== exp_q[0] || instructions !== memf(exp_q[0]))
          $display("FAIL rdf_head c%0d: got %h/%h need %h/%h", i, pc_out, instructions, exp_q[0], memf(exp_q[0]));
        else pass_cnt++;
        if (id_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (i == 4) begin
        chk_cnt++;
        if (id_valid !== 1'b1) $display("FAIL rdf_full: id_valid got %b need 1", id_valid); else pass_cnt++;
      end
      if (i == 5) begin
        chk_cnt++;
        if (id_valid !== 1'b0) $display("FAIL rdf_flush: id_valid got %b need 0", id_valid); else pass_cnt++;
      end
      if (rd) begin exp_q.delete(); exp_addr = {tg[31:2], 2'b00}; end
      else if (exp_req) begin exp_q.push_back(exp_addr); exp_addr += 32'd4; end
    end
  endtask

  task automatic test_reset_midop();
    int occ;
    logic exp_req;
    logic rs;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rs = (i == 3);
      rst = rs; redirect = 1'b0; redirect_target = '0; id_ready = 1'b1;
      #1;
      occ = exp_q.size();
      if (id_valid === 1'b1 && id_ready) occ--;
      exp_req = !rs && (occ < int'(DEPTH));
      chk_cnt++;
      if (imem_req !== exp_req) $display("FAIL rst_req c%0d: got %b need %b", i, imem_req, exp_req); else pass_cnt++;
      if (exp_req && imem_req === 1'b1) begin
        chk_cnt++;
        if (imem_addr !== exp_addr) $display("FAIL rst_addr c%0d: got %h need %h", i, imem_addr, exp_addr); else pass_cnt++;
      end
      if (!rs && id_valid === 1'b1) begin
        chk_cnt++;
        if (exp_q.size() == 0) $display("FAIL rst_head c%0d: unexpected pc %h", i, pc_out);
        else if (pc_out !== exp_q[0] || instructions !== memf(exp_q[0]))
          $display("FAIL rst_head c%0d: got %h/%h need %h/%h", i, pc_out, instructions, exp_q[0], memf(exp_q[0]));
        else pass_cnt++;
        if (id_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (i == 4) begin
        chk_cnt++;
        if (id_valid !== 1'b0 || pc_out !== 32'h0 || instructions !== 32'h0)
          $display("FAIL rst_outputs: valid %b pc %h instr %h need 0 0 0", id_valid, pc_out, instructions);
        else pass_cnt++;
      end
      if (rs) begin exp_q.delete(); exp_addr = RESET_PC; end
      else if (exp_req) begin exp_q.push_back(exp_addr); exp_addr += 32'd4; end
    end
  endtask

  task automatic test_pc_wrap();
    int occ;
    int n = 0;
    logic exp_req;
    logic rd;
    logic [31:0] tg;
    logic [31:0] seen [4];
    logic [31:0] want [4];
    want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0000_0000; want[3] = 32'h0000_0004;
    for (int k = 0; k < 4; k++) seen[k] = 32'hxxxx_xxxx;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rd = (i == 0);
      tg = 32'hFFFF_FFF8;
      rst = 1'b0; redirect = rd; redirect_target = tg; id_ready = 1'b1;
      #1;
      if (!rd && imem_req === 1'b1 && n < 4) begin seen[n] = imem_addr; n++; end
      occ = exp_q.size();
      if (id_valid === 1'b1 && id_ready) occ--;
      exp_req = !rd && (occ < int'(DEPTH));
      chk_cnt++;
      if (imem_req !== exp_req) $display("FAIL wrap_req c%0d: got %b need %b", i, imem_req, exp_req); else pass_cnt++;
      if (id_valid === 1'b1) begin
        chk_cnt++;
        if (exp_q.size() == 0) $display("FAIL wrap_head c%0d: unexpected pc %h", i, pc_out);
        else if (pc_out !== exp_q[0] || instructions !== memf(exp_q[0]))
          $display("FAIL wrap_head c%0d: got %h/%h need %h/%h", i, pc_out, instructions, exp_q[0], memf(exp_q[0]));
        else pass_cnt++;
        if (id_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (rd) begin exp_q.delete(); exp_addr = {tg[31:2], 2'b00}; end
      else if (exp_req) begin exp_q.push_back(exp_addr); exp_addr += 32'd4; end
    end
    for (int k = 0; k < 4; k++) begin
      chk_cnt++;
      if (seen[k] !== want[k]) $display("FAIL wrap_addr%0d: got %h need %h", k, seen[k], want[k]); else pass_cnt++;
    end
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_target = '0; id_ready = 1'b0;
    exp_addr = RESET_PC;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_full();
    test_reset_midop();
    test_pc_wrap();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
